// File: rtl/rom_responder.sv
// Program-memory responder for the 4-bit CPU bus: follows the 8-subcycle fetch
// cycle from sync, captures address/chip select and returns the opcode nibbles.
module rom_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sync,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_oe,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [2:0] cycle,
    output logic       locked,
    output logic       sync_error
);

    logic [2:0] cycle_q, cycle_d;
    logic       locked_q, locked_d;
    logic       sync_error_q, sync_error_d;
    logic       selected_q, selected_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] word_q, word_d;
    logic [7:0] mem_q [256];

    always_comb begin
        cycle_d      = cycle_q + 3'd1;
        locked_d     = locked_q;
        sync_error_d = sync_error_q;
        selected_d   = selected_q;
        addr_d       = addr_q;
        word_d       = word_q;

        if (locked_q) begin
            case (cycle_q)
                3'd0: addr_d[3:0] = data_in;
                3'd1: addr_d[7:4] = data_in;
                3'd2: begin
                    word_d     = mem_q[addr_q];
                    selected_d = (data_in == CHIP_ID);
                end
                3'd7: selected_d = 1'b0;
                default: ;
            endcase
        end

        // The sync-low edge is the CPU's end of subcycle 7, so select ends there too.
        if (!sync) begin
            cycle_d    = 3'd0;
            locked_d   = 1'b1;
            selected_d = 1'b0;
            if (locked_q && (cycle_q != 3'd7)) begin
                sync_error_d = 1'b1;
            end
        end else if (locked_q && (cycle_q == 3'd7)) begin
            locked_d     = 1'b0;
            sync_error_d = 1'b1;
            selected_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q      <= 3'd0;
            locked_q     <= 1'b0;
            sync_error_q <= 1'b0;
            selected_q   <= 1'b0;
            addr_q       <= 8'd0;
            word_q       <= 8'd0;
        end else begin
            cycle_q      <= cycle_d;
            locked_q     <= locked_d;
            sync_error_q <= sync_error_d;
            selected_q   <= selected_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
        end
    end

    // Program store survives reset; a same-edge write is seen by the next fetch.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign data_oe    = locked_q & selected_q & ((cycle_q == 3'd3) | (cycle_q == 3'd4));
    assign data_out   = (cycle_q == 3'd3) ? word_q[7:4] : word_q[3:0];
    assign cycle      = cycle_q;
    assign locked     = locked_q;
    assign sync_error = sync_error_q;

endmodule

// File: tb/tb_rom_responder.sv
// Self-checking bench for rom_responder: acts as the CPU bus master and checks
// returned opcodes against a behavioural model of the program store and lock state.
module tb_rom_responder;

    localparam logic [3:0] TB_CHIP = 4'h3;

    logic       clock;
    logic       reset;
    logic       sync;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_oe;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] cycle;
    logic       locked;
    logic       sync_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_m [256];
    bit         m_locked;
    bit         m_err;

    rom_responder #(.CHIP_ID(TB_CHIP)) dut (
        .clock     (clock),
        .reset     (reset),
        .sync      (sync),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .cycle     (cycle),
        .locked    (locked),
        .sync_error(sync_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One CPU instruction cycle. sync_sub = subcycle with sync low (8 = withheld).
    task automatic cpu_cycle(input logic [7:0] a, input logic [3:0] chip, input int sync_sub,
                             input bit wr2, input logic [7:0] wdat);
        bit         sel;
        bit         exp_oe;
        logic [7:0] exp_word;
        logic [3:0] exp_nib;
        sel      = m_locked && (chip == TB_CHIP);
        exp_word = mem_m[a];
        for (int k = 0; k < 8; k++) begin
            case (k)
                0:       data_in = a[3:0];
                1:       data_in = a[7:4];
                2:       data_in = chip;
                default: data_in = 4'($urandom_range(0, 15));
            endcase
            sync      = (k == sync_sub) ? 1'b0 : 1'b1;
            prog_we   = wr2 && (k == 2);
            prog_addr = a;
            prog_data = wdat;
            exp_oe    = sel && (k == 3 || k == 4);
            if (m_locked) begin
                n_checks++;
                if (cycle !== 3'(k)) begin
                    n_fail++;
                    $display("FAIL cycle_track: got %0d expected %0d", cycle, k);
                end
            end
            n_checks++;
            if (data_oe !== exp_oe) begin
                n_fail++;
                $display("FAIL data_oe a=%02h sub=%0d: got %0b expected %0b", a, k, data_oe, exp_oe);
            end
            if (exp_oe) begin
                exp_nib = (k == 3) ? exp_word[7:4] : exp_word[3:0];
                n_checks++;
                if (data_out !== exp_nib) begin
                    n_fail++;
                    $display("FAIL data_out a=%02h sub=%0d: got %0h expected %0h", a, k, data_out, exp_nib);
                end
            end
            n_checks++;
            if (locked !== m_locked || sync_error !== m_err) begin
                n_fail++;
                $display("FAIL lock_state sub=%0d: got locked=%0b err=%0b expected locked=%0b err=%0b",
                         k, locked, sync_error, m_locked, m_err);
            end
            tick();
            if (k == sync_sub) break;
        end
        sync    = 1'b1;
        prog_we = 1'b0;
        if (wr2) mem_m[a] = wdat;
        if (sync_sub < 7) begin
            if (m_locked) m_err = 1'b1;
            m_locked = 1'b1;
        end else if (sync_sub == 7) begin
            m_locked = 1'b1;
        end else if (m_locked) begin
            m_locked = 1'b0;
            m_err    = 1'b1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (cycle !== 3'd0 || locked !== 1'b0 || sync_error !== 1'b0 ||
            data_oe !== 1'b0 || data_out !== 4'h0) begin
            n_fail++;
            $display("FAIL %s: got cycle=%0d locked=%0b err=%0b oe=%0b out=%0h expected all zero",
                     tag, cycle, locked, sync_error, data_oe, data_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        check_reset_values("reset_values");
        reset    = 1'b0;
        m_locked = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 8'($urandom_range(0, 255));
        end
        mem_m[8'h12] = 8'hD7;
        mem_m[8'h40] = 8'h11;
        for (int i = 0; i < 256; i++) begin
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = mem_m[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic test_unlocked();
        for (int i = 0; i < 8; i++) begin
            data_in = 4'($urandom_range(0, 15));
            n_checks++;
            if (locked !== 1'b0 || data_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL unlocked: got locked=%0b oe=%0b expected 0 0", locked, data_oe);
            end
            tick();
        end
        // CPU's first instruction cycle: responder not yet aligned, then sync aligns it.
        cpu_cycle(8'($urandom_range(0, 255)), TB_CHIP, 7, 1'b0, 8'h00);
        n_checks++;
        if (locked !== 1'b1 || cycle !== 3'd0) begin
            n_fail++;
            $display("FAIL align: got locked=%0b cycle=%0d expected 1 0", locked, cycle);
        end
    endtask

    task automatic test_basic_fetch();
        cpu_cycle(8'h12, TB_CHIP, 7, 1'b0, 8'h00);
    endtask

    task automatic test_random_fetch();
        logic [3:0] chip;
        for (int i = 0; i < 20; i++) begin
            chip = ($urandom_range(0, 1) == 1) ? TB_CHIP : 4'($urandom_range(0, 15));
            cpu_cycle(8'($urandom_range(0, 255)), chip, 7, 1'b0, 8'h00);
        end
    endtask

    task automatic test_chip_mismatch();
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        cpu_cycle(a, 4'h0, 7, 1'b0, 8'h00);
        cpu_cycle(a, TB_CHIP, 7, 1'b0, 8'h00);
    endtask

    task automatic test_write_collision();
        cpu_cycle(8'h40, TB_CHIP, 7, 1'b1, 8'h22);
        cpu_cycle(8'h40, TB_CHIP, 7, 1'b0, 8'h00);
    endtask

    task automatic test_early_sync();
        cpu_cycle(8'h12, TB_CHIP, 3, 1'b0, 8'h00);
        n_checks++;
        if (cycle !== 3'd0 || data_oe !== 1'b0 || sync_error !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL early_sync: got cycle=%0d oe=%0b err=%0b locked=%0b expected 0 0 1 1",
                     cycle, data_oe, sync_error, locked);
        end
        cpu_cycle(8'($urandom_range(0, 255)), TB_CHIP, 7, 1'b0, 8'h00);
    endtask

    task automatic test_lock_loss();
        cpu_cycle(8'($urandom_range(0, 255)), TB_CHIP, 8, 1'b0, 8'h00);
        n_checks++;
        if (locked !== 1'b0 || sync_error !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_loss: got locked=%0b err=%0b expected 0 1", locked, sync_error);
        end
        cpu_cycle(8'($urandom_range(0, 255)), TB_CHIP, 7, 1'b0, 8'h00);
        cpu_cycle(8'h12, TB_CHIP, 7, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] a;
        a = 8'h12;
        for (int k = 0; k < 3; k++) begin
            data_in = (k == 0) ? a[3:0] : (k == 1) ? a[7:4] : TB_CHIP;
            tick();
        end
        n_checks++;
        if (data_oe !== 1'b1 || data_out !== mem_m[a][7:4]) begin
            n_fail++;
            $display("FAIL pre_reset_drive: got oe=%0b out=%0h expected 1 %0h", data_oe, data_out, mem_m[a][7:4]);
        end
        reset = 1'b1;
        tick();
        check_reset_values("reset_mid_fetch");
        reset    = 1'b0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        tick();
        n_checks++;
        if (data_oe !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got oe=%0b locked=%0b expected 0 0", data_oe, locked);
        end
        cpu_cycle(8'($urandom_range(0, 255)), TB_CHIP, 7, 1'b0, 8'h00);
        cpu_cycle(8'h40, TB_CHIP, 7, 1'b0, 8'h00);
    endtask

    initial begin
        reset     = 1'b1;
        sync      = 1'b1;
        data_in   = 4'h0;
        prog_we   = 1'b0;
        prog_addr = 8'h00;
        prog_data = 8'h00;
        m_locked  = 1'b0;
        m_err     = 1'b0;
        test_reset();
        load_program();
        test_unlocked();
        test_basic_fetch();
        test_random_fetch();
        test_chip_mismatch();
        test_write_collision();
        test_early_sync();
        test_lock_loss();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
